// File: rtl/burst_launch_pkg.sv
// Shared types and defaults for the burst launcher feeding the base/addr/cnt counter.
package burst_launch_pkg;

  localparam int W_DEF  = 16;
  localparam int LW_DEF = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  // Length fields encode beats-1, so a zero field still means one beat.
  function automatic int unsigned beats_from_len(input int unsigned len);
    return len + 1;
  endfunction

endpackage

// File: rtl/burst_launch_arb_if.sv
// Requester handshakes plus the counter load pair and burst status.
interface burst_launch_arb_if #(
  parameter int W  = 16,
  parameter int LW = 8
) ();

  logic          req0_valid;
  logic [W-1:0]  req0_addr;
  logic [LW-1:0] req0_len;
  logic          req0_ready;
  logic          req1_valid;
  logic [W-1:0]  req1_addr;
  logic [LW-1:0] req1_len;
  logic          req1_ready;
  logic          load_en;
  logic [W-1:0]  load_addr;
  logic          busy;
  logic          grant_id;
  logic          beat_last;

  modport master (
    output req0_valid, req0_addr, req0_len,
    input  req0_ready,
    output req1_valid, req1_addr, req1_len,
    input  req1_ready,
    input  load_en, load_addr, busy, grant_id, beat_last
  );

  modport slave (
    input  req0_valid, req0_addr, req0_len,
    output req0_ready,
    input  req1_valid, req1_addr, req1_len,
    output req1_ready,
    output load_en, load_addr, busy, grant_id, beat_last
  );

endinterface

// File: rtl/burst_launch_arb_rr_arb2.sv
// Two-way round-robin pick: the pointer only breaks ties, a lone valid always wins.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       ptr,
  input  logic       en,
  output logic [1:0] grant
);

  for (genvar gi = 0; gi < 2; gi++) begin : g_pick
    assign grant[gi] = en & valid[gi] & (~valid[1-gi] | (ptr == 1'(gi)));
  end

endmodule

// File: rtl/burst_launch_arb.sv
// Round-robin burst launcher: pulses the counter load once per burst, then lets it free-run.
module burst_launch_arb
  import burst_launch_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int LW = LW_DEF
) (
  input logic               clk,
  input logic               rst,
  burst_launch_arb_if.slave bus
);

  state_t        state_reg, state_next;
  logic [LW-1:0] remaining_reg, remaining_next;
  logic          rr_ptr_reg, rr_ptr_next;
  logic          load_en_reg, load_en_next;
  logic [W-1:0]  load_addr_reg, load_addr_next;
  logic          grant_id_reg, grant_id_next;
  logic          beat_last_reg, beat_last_next;

  logic          accept_ok;
  logic [1:0]    valids;
  logic [1:0]    grant;
  logic          winner;

  // A new burst may be taken during the final beat, giving zero-bubble chaining.
  assign accept_ok = ~rst & ((state_reg == IDLE) | (remaining_reg == '0));
  assign valids    = {bus.req1_valid, bus.req0_valid};

  rr_arb2 u_arb (
    .valid (valids),
    .ptr   (rr_ptr_reg),
    .en    (accept_ok),
    .grant (grant)
  );

  assign bus.req0_ready = grant[0];
  assign bus.req1_ready = grant[1];
  assign bus.load_en    = load_en_reg;
  assign bus.load_addr  = load_addr_reg;
  assign bus.busy       = (state_reg == BURST);
  assign bus.grant_id   = grant_id_reg;
  assign bus.beat_last  = beat_last_reg;

  always_comb begin
    state_next     = state_reg;
    remaining_next = remaining_reg;
    rr_ptr_next    = rr_ptr_reg;
    load_en_next   = 1'b0;
    load_addr_next = load_addr_reg;
    grant_id_next  = grant_id_reg;
    beat_last_next = 1'b0;
    winner         = grant[1];

    if (grant != 2'b00) begin
      state_next     = BURST;
      load_en_next   = 1'b1;
      load_addr_next = winner ? bus.req1_addr : bus.req0_addr;
      remaining_next = winner ? bus.req1_len : bus.req0_len;
      grant_id_next  = winner;
      rr_ptr_next    = ~winner;
      beat_last_next = (remaining_next == '0);
    end else if (state_reg == BURST) begin
      if (remaining_reg != '0) begin
        remaining_next = remaining_reg - LW'(1);
        beat_last_next = (remaining_reg == LW'(1));
      end else begin
        state_next = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      remaining_reg <= '0;
      rr_ptr_reg    <= 1'b0;
      load_en_reg   <= 1'b0;
      load_addr_reg <= '0;
      grant_id_reg  <= 1'b0;
      beat_last_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      remaining_reg <= remaining_next;
      rr_ptr_reg    <= rr_ptr_next;
      load_en_reg   <= load_en_next;
      load_addr_reg <= load_addr_next;
      grant_id_reg  <= grant_id_next;
      beat_last_reg <= beat_last_next;
    end
  end

endmodule

// File: tb/tb_burst_launch_arb.sv
// Bench for burst_launch_arb: fixed vector table, directed corner sequences, random traffic vs a timeline model.
module tb_burst_launch_arb;
  import burst_launch_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  burst_launch_arb_if #(.W(16), .LW(8)) bus ();

  burst_launch_arb #(.W(16), .LW(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors   = 0;
  int n_checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        rst, v0;
    logic [15:0] a0;
    logic [7:0]  l0;
    logic        v1;
    logic [15:0] a1;
    logic [7:0]  l1;
    logic        r0, r1, le;
    logic [15:0] la;
    logic        busy, gid, bl;
  } vec_t;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  function automatic vec_t mk(input logic rs, input logic v0, input logic [15:0] a0, input logic [7:0] l0,
                              input logic v1, input logic [15:0] a1, input logic [7:0] l1,
                              input logic r0, input logic r1, input logic le, input logic [15:0] la,
                              input logic bz, input logic gid, input logic bl);
    vec_t v;
    v.rst = rs; v.v0 = v0; v.a0 = a0; v.l0 = l0; v.v1 = v1; v.a1 = a1; v.l1 = l1;
    v.r0 = r0; v.r1 = r1; v.le = le; v.la = la; v.busy = bz; v.gid = gid; v.bl = bl;
    return v;
  endfunction

  // Timeline model: a burst accepted in cycle c occupies cycles c+1 .. c+beats.
  int          cyc = 0;
  int          start_c = -10;
  int          end_c = -10;
  logic [15:0] m_addr = '0;
  logic        m_gid = 1'b0;
  logic        m_ptr = 1'b0;
  logic        seen_r0, seen_r1, seen_le, seen_busy, seen_gid, seen_bl;
  logic [15:0] seen_la;

  task automatic drive(input logic r, input logic v0, input logic [15:0] a0, input logic [7:0] l0,
                       input logic v1, input logic [15:0] a1, input logic [7:0] l1);
    rst = r;
    bus.req0_valid = v0; bus.req0_addr = a0; bus.req0_len = l0;
    bus.req1_valid = v1; bus.req1_addr = a1; bus.req1_len = l1;
  endtask

  task automatic sample();
    seen_r0 = bus.req0_ready; seen_r1 = bus.req1_ready;
    seen_le = bus.load_en; seen_la = bus.load_addr; seen_busy = bus.busy;
    seen_gid = bus.grant_id; seen_bl = bus.beat_last;
  endtask

  task automatic step(input logic r, input logic v0, input logic [15:0] a0, input logic [7:0] l0,
                      input logic v1, input logic [15:0] a1, input logic [7:0] l1, input bit do_chk);
    logic m_busy, acc_ok;
    int   w;
    drive(r, v0, a0, l0, v1, a1, l1);
    @(negedge clk);
    sample();
    m_busy = (cyc >= start_c) && (cyc <= end_c);
    acc_ok = !r && (!m_busy || cyc == end_c);
    w = -1;
    if (acc_ok) begin
      if (v0 && v1) w = int'(m_ptr);
      else if (v0)  w = 0;
      else if (v1)  w = 1;
    end
    if (do_chk) begin
      chk("ready0", 32'(seen_r0), 32'(w == 0));
      chk("ready1", 32'(seen_r1), 32'(w == 1));
      chk("load_en", 32'(seen_le), 32'(cyc == start_c));
      chk("load_addr", 32'(seen_la), 32'(m_addr));
      chk("busy", 32'(seen_busy), 32'(m_busy));
      chk("grant_id", 32'(seen_gid), 32'(m_gid));
      chk("beat_last", 32'(seen_bl), 32'(cyc == end_c));
    end
    if (r) begin
      start_c = -10; end_c = -10; m_addr = '0; m_gid = 1'b0; m_ptr = 1'b0;
    end else if (w >= 0) begin
      start_c = cyc + 1;
      end_c   = cyc + int'(beats_from_len(32'(w == 1 ? l1 : l0)));
      m_addr  = (w == 1) ? a1 : a0;
      m_gid   = (w == 1);
      m_ptr   = (w == 0);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t vecs[12];
  int   le_cyc[$];
  int   le_gid[$];
  int   busy_cnt, le_cnt;
  logic p0, p1, rr;
  logic [15:0] ra0, ra1;
  logic [7:0]  rl0, rl1;

  initial begin
    vecs[0]  = mk(H, H, 16'h7604, 8'd3, L, 16'h0,    8'd0, L, L, L, 16'h0,    L, L, L);
    vecs[1]  = mk(H, H, 16'h7604, 8'd3, H, 16'h0,    8'd0, L, L, L, 16'h0,    L, L, L);
    vecs[2]  = mk(L, H, 16'h7604, 8'd3, L, 16'h0,    8'd0, H, L, L, 16'h0,    L, L, L);
    vecs[3]  = mk(L, L, 16'h0,    8'd0, L, 16'h0,    8'd0, L, L, H, 16'h7604, H, L, L);
    vecs[4]  = mk(L, L, 16'h0,    8'd0, L, 16'h0,    8'd0, L, L, L, 16'h7604, H, L, L);
    vecs[5]  = mk(L, L, 16'h0,    8'd0, L, 16'h0,    8'd0, L, L, L, 16'h7604, H, L, L);
    vecs[6]  = mk(L, L, 16'h0,    8'd0, L, 16'h0,    8'd0, L, L, L, 16'h7604, H, L, H);
    vecs[7]  = mk(H, H, 16'h1111, 8'd0, H, 16'h2222, 8'd0, L, L, L, 16'h7604, L, L, L);
    vecs[8]  = mk(L, H, 16'h1111, 8'd0, H, 16'h2222, 8'd0, H, L, L, 16'h0,    L, L, L);
    vecs[9]  = mk(L, L, 16'h0,    8'd0, H, 16'h2222, 8'd0, L, H, H, 16'h1111, H, L, H);
    vecs[10] = mk(L, L, 16'h0,    8'd0, L, 16'h0,    8'd0, L, L, H, 16'h2222, H, H, H);
    vecs[11] = mk(L, L, 16'h0,    8'd0, L, 16'h0,    8'd0, L, L, L, 16'h2222, L, H, L);

    drive(H, L, '0, '0, L, '0, '0);
    @(posedge clk);
    #1;

    // Reset, lone req0 burst of 4 beats, then both valid out of reset with len=0.
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].rst, vecs[i].v0, vecs[i].a0, vecs[i].l0, vecs[i].v1, vecs[i].a1, vecs[i].l1);
      @(negedge clk);
      sample();
      chk($sformatf("v%0d.ready0", i), 32'(seen_r0), 32'(vecs[i].r0));
      chk($sformatf("v%0d.ready1", i), 32'(seen_r1), 32'(vecs[i].r1));
      chk($sformatf("v%0d.load_en", i), 32'(seen_le), 32'(vecs[i].le));
      chk($sformatf("v%0d.load_addr", i), 32'(seen_la), 32'(vecs[i].la));
      chk($sformatf("v%0d.busy", i), 32'(seen_busy), 32'(vecs[i].busy));
      chk($sformatf("v%0d.grant_id", i), 32'(seen_gid), 32'(vecs[i].gid));
      chk($sformatf("v%0d.beat_last", i), 32'(seen_bl), 32'(vecs[i].bl));
      $display("vec %0d: ready=%b%b load_en=%b addr=%h busy=%b gid=%b last=%b",
               i, seen_r1, seen_r0, seen_le, seen_la, seen_busy, seen_gid, seen_bl);
      @(posedge clk);
      #1;
    end

    // Continuous contention with len=2: alternating owners, a load every third cycle.
    step(H, L, '0, '0, L, '0, '0, 1'b0);
    for (int i = 0; i < 14; i++) begin
      step(L, H, 16'h0A00, 8'd2, H, 16'h0B00, 8'd2, 1'b1);
      if (seen_le) begin
        le_cyc.push_back(cyc);
        le_gid.push_back(int'(seen_gid));
      end
    end
    chk("t4.load_count", 32'(le_cyc.size() >= 4), 32'd1);
    for (int i = 1; i < le_cyc.size(); i++) begin
      chk($sformatf("t4.spacing%0d", i), 32'(le_cyc[i] - le_cyc[i-1]), 32'd3);
      chk($sformatf("t4.alternate%0d", i), 32'(le_gid[i]), 32'(1 - le_gid[i-1]));
    end
    $display("t4: %0d loads, first owner %0d", le_cyc.size(), le_gid.size() > 0 ? le_gid[0] : -1);

    // Maximum length burst starting near the top of the address space.
    step(H, L, '0, '0, L, '0, '0, 1'b1);
    p0 = 1'b1; busy_cnt = 0; le_cnt = 0;
    for (int i = 0; i < 270; i++) begin
      step(L, p0, 16'hFFFE, 8'hFF, L, '0, '0, 1'b1);
      if (seen_r0) p0 = 1'b0;
      if (seen_busy) busy_cnt++;
      if (seen_le) le_cnt++;
    end
    chk("t5.busy_cycles", 32'(busy_cnt), 32'd256);
    chk("t5.load_pulses", 32'(le_cnt), 32'd1);
    $display("t5: busy %0d cycles, %0d load pulses", busy_cnt, le_cnt);

    // Reset during beat 2 of a 6-beat burst while req1 waits.
    step(H, L, '0, '0, L, '0, '0, 1'b1);
    step(L, H, 16'h0100, 8'd5, L, '0, '0, 1'b1);
    step(L, L, '0, '0, H, 16'h0300, 8'd1, 1'b1);
    step(H, L, '0, '0, H, 16'h0300, 8'd1, 1'b1);
    chk("t6.ready_in_rst", 32'(seen_r1), 32'd0);
    step(L, L, '0, '0, H, 16'h0300, 8'd1, 1'b1);
    chk("t6.busy_after_rst", 32'(seen_busy), 32'd0);
    chk("t6.req1_accepted", 32'(seen_r1), 32'd1);
    for (int i = 0; i < 3; i++) step(L, L, '0, '0, L, '0, '0, 1'b1);
    $display("t6: reset mid-burst, req1 relaunched");

    // Random traffic with requesters holding their burst until accepted.
    p0 = 1'b0; p1 = 1'b0; ra0 = '0; ra1 = '0; rl0 = '0; rl1 = '0;
    for (int i = 0; i < 400; i++) begin
      if (!p0 && $urandom_range(0, 2) == 0) begin
        p0 = 1'b1; ra0 = 16'($urandom);
        rl0 = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 40)) : 8'($urandom_range(0, 3));
      end
      if (!p1 && $urandom_range(0, 2) == 0) begin
        p1 = 1'b1; ra1 = 16'($urandom);
        rl1 = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 40)) : 8'($urandom_range(0, 3));
      end
      rr = ($urandom_range(0, 49) == 0);
      step(rr, p0, ra0, rl0, p1, ra1, rl1, 1'b1);
      if (seen_r0) p0 = 1'b0;
      if (seen_r1) p1 = 1'b0;
    end
    $display("random: 400 cycles done");

    $display("Result: errors=%0d of %0d checks", errors, n_checks);
    $finish;
  end

endmodule
